// File: rtl/xbtn_reader.sv
// Purpose : debounced push-button reader with press/release event registers and a level IRQ.
// Latency : a stable btn change updates LEVEL on the (thr+2)-th clk edge; bus reads are combinational.
// Backpres: none; single-cycle register bus, every access completes in the cycle it is presented.
//
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   btn[NBTN]      - raw asynchronous button levels, 1 = pressed
//   sel, we, addr  - register bus strobe, write enable, register index
//   data_in        - bus write data
//   data_out       - bus read data (0 when sel is low)
//   irq            - OR of all pending press events
//
// Register map: 0 LEVEL (RO), 1 PRESS (clear-on-read, W1C), 2 RELEASE (clear-on-read, W1C), 3 THR (RW).
module xbtn_reader #(
    parameter int DATA_W = 32,
    parameter int NBTN   = 4,
    parameter int DB_W   = 20,
    parameter int DB_DEF = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NBTN-1:0]   btn,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam logic [1:0]      A_LEVEL   = 2'd0;
    localparam logic [1:0]      A_PRESS   = 2'd1;
    localparam logic [1:0]      A_RELEASE = 2'd2;
    localparam logic [1:0]      A_THR     = 2'd3;
    localparam logic [DB_W-1:0] THR_RST   = DB_W'(DB_DEF);
    localparam logic [DB_W-1:0] CNT_ONE   = DB_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] prs_evt;
    logic [NBTN-1:0] rel_evt;
    logic [DB_W-1:0] thr;
    logic [DB_W-1:0] cnt     [NBTN];

    // Next-state
    logic [NBTN-1:0] level_nxt;
    logic [NBTN-1:0] prs_nxt;
    logic [NBTN-1:0] rel_nxt;
    logic [DB_W-1:0] thr_nxt;
    logic [DB_W-1:0] cnt_nxt [NBTN];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic            rd;
    logic            wr;
    logic            thr_wr;
    logic [NBTN-1:0] prs_clr;
    logic [NBTN-1:0] rel_clr;
    logic [NBTN-1:0] prs_set;
    logic [NBTN-1:0] rel_set;
    logic [DB_W-1:0] thr_m1;

    assign rd     = sel & ~we;
    assign wr     = sel & we;
    assign thr_wr = wr && (addr == A_THR);

    // A read clears every bit of the addressed event register; a write
    // clears only the bits written as 1. Both are masked by the set terms below.
    always_comb begin
        prs_clr = '0;
        rel_clr = '0;
        if (rd && addr == A_PRESS)   prs_clr = '1;
        if (wr && addr == A_PRESS)   prs_clr = data_in[NBTN-1:0];
        if (rd && addr == A_RELEASE) rel_clr = '1;
        if (wr && addr == A_RELEASE) rel_clr = data_in[NBTN-1:0];
    end

    // A threshold of 0 would never match cnt == thr-1 in the intended way,
    // so it is folded onto 1 (terminal count 0).
    assign thr_m1 = (thr == '0) ? '0 : (thr - CNT_ONE);

    // ------------------------------------------------------------------
    // Debounce: a button's level only follows sync2 after sync2 has
    // disagreed with it for thr consecutive edges. Any agreement in
    // between drops the count back to zero.
    // ------------------------------------------------------------------
    always_comb begin
        level_nxt = level;
        for (int i = 0; i < NBTN; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        for (int i = 0; i < NBTN; i++) begin
            if (thr_wr) begin
                // Threshold change restarts every count; level is held.
                cnt_nxt[i] = '0;
            end else if (sync2[i] == level[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == thr_m1) begin
                level_nxt[i] = sync2[i];
                cnt_nxt[i]   = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    // Event edges come from the level transition being committed this edge.
    assign prs_set = level_nxt & ~level;
    assign rel_set = ~level_nxt & level;

    // Set has priority over any coincident clear.
    assign prs_nxt = (prs_evt & ~prs_clr) | prs_set;
    assign rel_nxt = (rel_evt & ~rel_clr) | rel_set;
    assign thr_nxt = thr_wr ? data_in[DB_W-1:0] : thr;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            prs_evt <= '0;
            rel_evt <= '0;
            thr     <= THR_RST;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level   <= level_nxt;
            prs_evt <= prs_nxt;
            rel_evt <= rel_nxt;
            thr     <= thr_nxt;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Pending presses drive the interrupt straight from the event flops.
    assign irq = |prs_evt;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                A_LEVEL:   data_out[NBTN-1:0] = level;
                A_PRESS:   data_out[NBTN-1:0] = prs_evt;
                A_RELEASE: data_out[NBTN-1:0] = rel_evt;
                A_THR:     data_out[DB_W-1:0] = thr;
                default:   data_out = '0;
            endcase
        end
    end

    // Write data above the threshold field has no destination.
    if (DATA_W > DB_W) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^data_in[DATA_W-1:DB_W];
    end

endmodule

// File: tb/tb_xbtn_reader.sv
module tb_xbtn_reader;

    localparam int DATA_W = 32;
    localparam int NBTN   = 4;
    localparam int DB_W   = 20;
    localparam int DB_DEF = 500000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NBTN-1:0]   btn;
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              irq;

    int total = 0;
    int bad   = 0;

    xbtn_reader #(
        .DATA_W(DATA_W),
        .NBTN  (NBTN),
        .DB_W  (DB_W),
        .DB_DEF(DB_DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        cd;
        logic [31:0] dout;
        logic        ir;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic cd, input logic [31:0] dout, input logic ir);
        vec_t v;
        v.s = s; v.w = w; v.a = a; v.d = d; v.b = b; v.cd = cd; v.dout = dout; v.ir = ir;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge; outputs are sampled 1ns later.
    task automatic step(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; we = w; addr = a; data_in = d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0; btn = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dout_nosel", data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 2'd3, 0); chk("rst_thr", data_out, DB_DEF);
        step(1, 0, 2'd0, 0); chk("rst_level", data_out, 32'd0);
        step(1, 0, 2'd1, 0); chk("rst_press", data_out, 32'd0);
        step(1, 0, 2'd2, 0); chk("rst_release", data_out, 32'd0);

        // ---------------- table: THR=4, btn[0] press, read-clear, sel gating, bounce ----------------
        add(1, 1, 2'd3, 32'd4, 4'h0, 0, 0, 0);        // write THR=4
        add(1, 0, 2'd3, 0,     4'h0, 1, 4, 0);        // THR readback
        for (int k = 0; k < 6; k++)
            add(1, 0, 2'd0, 0, 4'h1, 1, 0, 0);        // btn[0] high, level still 0 through edge 5
        add(1, 0, 2'd0, 0, 4'h1, 1, 1, 1);            // after 6th edge: LEVEL=1, irq=1
        add(1, 0, 2'd1, 0, 4'h1, 1, 1, 1);            // read PRESS returns 1 and clears
        add(1, 0, 2'd1, 0, 4'h1, 1, 0, 0);            // PRESS now 0, irq 0
        add(0, 0, 2'd3, 0, 4'h1, 1, 0, 0);            // sel=0 -> data_out 0
        add(0, 1, 2'd3, 32'd9, 4'h1, 1, 0, 0);        // write without sel ignored
        add(1, 0, 2'd3, 0, 4'h1, 1, 4, 0);            // THR still 4
        for (int k = 0; k < 3; k++) add(1, 0, 2'd0, 0, 4'h3, 1, 1, 0);  // btn[1] high 3
        for (int k = 0; k < 2; k++) add(1, 0, 2'd0, 0, 4'h1, 1, 1, 0);  // low 2
        for (int k = 0; k < 3; k++) add(1, 0, 2'd0, 0, 4'h3, 1, 1, 0);  // high 3
        for (int k = 0; k < 4; k++) add(1, 0, 2'd0, 0, 4'h1, 1, 1, 0);  // settle
        add(1, 0, 2'd1, 0, 4'h1, 1, 0, 0);            // no press from the bounce
        add(1, 0, 2'd2, 0, 4'h1, 1, 0, 0);            // no release either
        add(1, 1, 2'd0, 32'hF, 4'h1, 0, 0, 0);        // write to LEVEL
        add(1, 0, 2'd0, 0, 4'h1, 1, 1, 0);            // LEVEL unchanged

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            sel = vq[i].s; we = vq[i].w; addr = vq[i].a; data_in = vq[i].d; btn = vq[i].b;
            #1;
            if (vq[i].cd) chk($sformatf("vec%0d_dout", i), data_out, vq[i].dout);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vq[i].ir));
        end

        // ---------------- read PRESS on the edge btn[2] level rises ----------------
        step(0, 0, 2'd0, 0); btn = 4'h5;
        idle(4);
        step(1, 0, 2'd1, 0); chk("race_old_val", data_out, 32'd0);
        chk("race_old_irq", 32'(irq), 32'd0);
        step(1, 0, 2'd1, 0); chk("race_set_wins", data_out, 32'h4);
        chk("race_irq", 32'(irq), 32'd1);
        step(1, 0, 2'd1, 0); chk("race_cleared", data_out, 32'd0);

        // ---------------- btn[3] press, W1C PRESS, release bits 2/3, W1C RELEASE ----------------
        step(0, 0, 2'd0, 0); btn = 4'hD;
        idle(5);
        step(1, 0, 2'd0, 0); chk("b3_level", data_out, 32'hD);
        chk("b3_irq", 32'(irq), 32'd1);
        step(1, 1, 2'd1, 32'h4);
        step(0, 0, 2'd0, 0); chk("w1c_other_bit_irq", 32'(irq), 32'd1);
        step(1, 1, 2'd1, 32'h8);
        step(0, 0, 2'd0, 0); chk("w1c_press_irq", 32'(irq), 32'd0);
        btn = 4'h1;
        idle(5);
        step(1, 0, 2'd0, 0); chk("rel_level", data_out, 32'h1);
        step(1, 1, 2'd2, 32'h8);
        step(1, 0, 2'd2, 0); chk("rel_after_w1c", data_out, 32'h4);
        step(1, 0, 2'd2, 0); chk("rel_after_read", data_out, 32'h0);
        step(1, 0, 2'd1, 0); chk("rel_no_press", data_out, 32'h0);

        // ---------------- THR write mid-count restarts the count ----------------
        step(0, 0, 2'd0, 0); btn = 4'h0;
        idle(3);
        step(1, 1, 2'd3, 32'd2);
        idle(1);
        step(1, 0, 2'd0, 0); chk("thrwr_level_hold", data_out, 32'h1);
        step(1, 0, 2'd0, 0); chk("thrwr_level_fall", data_out, 32'h0);
        step(1, 0, 2'd2, 0); chk("thrwr_release", data_out, 32'h1);

        // ---------------- reset with pending event and a count in progress ----------------
        step(0, 0, 2'd0, 0); btn = 4'h1;
        idle(3);
        step(0, 0, 2'd0, 0); chk("pre_rst_irq", 32'(irq), 32'd1);
        btn = 4'h0;
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_dout", data_out, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1, 0, 2'd3, 0); chk("post_rst_thr", data_out, DB_DEF);
        step(1, 0, 2'd0, 0); chk("post_rst_level", data_out, 32'd0);
        step(1, 0, 2'd1, 0); chk("post_rst_press", data_out, 32'd0);
        step(1, 0, 2'd2, 0); chk("post_rst_release", data_out, 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);

        // ---------------- THR=0 behaves as THR=1 ----------------
        step(1, 1, 2'd3, 32'd0);
        step(0, 0, 2'd0, 0); btn = 4'h2;
        idle(1);
        step(1, 0, 2'd0, 0); chk("thr0_level_edge2", data_out, 32'h0);
        step(1, 0, 2'd0, 0); chk("thr0_level_edge3", data_out, 32'h2);
        chk("thr0_irq", 32'(irq), 32'd1);
        step(1, 0, 2'd3, 0); chk("thr0_readback", data_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
